// File: rtl/sdram_port_mux.sv
// N-port SDRAM command multiplexer: fixed-priority or round-robin arbitration
// in front of one controller, with a tag FIFO that steers read data back to its port.
module sdram_port_mux #(
    parameter int N     = 4,
    parameter int AN    = 24,
    parameter int DN    = 16,
    parameter int RR    = 1,
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      we,
    input  logic [N*AN-1:0]   addr,
    input  logic [N*DN-1:0]   data,
    output logic [N-1:0]      rdy,
    output logic [N-1:0]      rd_valid,
    output logic [DN-1:0]     rd_data,
    output logic              if_req,
    output logic              if_we,
    output logic [AN-1:0]     if_addr,
    output logic [DN-1:0]     if_data,
    input  logic              if_rdy,
    input  logic              if_rdy_out,
    input  logic [DN-1:0]     if_data_out,
    output logic              err
);

    localparam int GW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]    state;
    logic [GW-1:0] grant;
    logic [GW-1:0] last;
    logic [GW-1:0] win;
    logic [GW-1:0] idx;
    logic          any_elig;
    logic [N-1:0]  elig;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [GW-1:0] tags [DEPTH];
    logic          hs;
    logic          push;
    logic          pop;

    assign if_req = (state == ISSUE);
    assign hs     = if_req && if_rdy;
    assign push   = hs && !if_we;
    assign pop    = if_rdy_out && (count != '0);

    // Reads are only admitted while the tag FIFO has room; writes always are.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            elig[i] = req[i] && (we[i] || (count < CW'(DEPTH)));
        end
    end

    // Scan starts after the last winner in round-robin mode, at port 0 otherwise.
    always_comb begin
        win      = '0;
        idx      = '0;
        any_elig = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (RR != 0) begin
                idx = GW'((int'(last) + 1 + k) % N);
            end else begin
                idx = GW'(k);
            end
            if (!any_elig && elig[idx]) begin
                any_elig = 1'b1;
                win      = idx;
            end
        end
    end

    always_comb begin
        rdy = '0;
        if (hs) begin
            rdy[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            last    <= GW'(N - 1);
            if_we   <= 1'b0;
            if_addr <= '0;
            if_data <= '0;
        end else if (state == IDLE) begin
            if (any_elig) begin
                state   <= ISSUE;
                grant   <= win;
                if_we   <= we[win];
                if_addr <= addr[win*AN +: AN];
                if_data <= data[win*DN +: DN];
            end
        end else if (if_rdy) begin
            state <= IDLE;
            if (RR != 0) begin
                last <= grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tags[wr_ptr] <= grant;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= '0;
            rd_data  <= '0;
            err      <= 1'b0;
        end else begin
            rd_valid <= '0;
            if (pop) begin
                rd_valid[tags[rd_ptr]] <= 1'b1;
                rd_data                <= if_data_out;
            end
            if (if_rdy_out && (count == '0)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_mux.sv
// Self-checking bench for sdram_port_mux: a round-robin instance and a
// fixed-priority instance, with a read-return scoreboard queue.
module tb_sdram_port_mux;

    localparam int N     = 4;
    localparam int AN    = 24;
    localparam int DN    = 16;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    req_fp;
    logic [N-1:0]    we;
    logic [N*AN-1:0] addr;
    logic [N*DN-1:0] data;
    logic            if_rdy;
    logic            if_rdy_out;
    logic [DN-1:0]   if_data_out;

    logic [N-1:0]    rdy, rd_valid, rdy_fp, rd_valid_fp;
    logic [DN-1:0]   rd_data, rd_data_fp, if_data, if_data_fp;
    logic            if_req, if_we, err, if_req_fp, if_we_fp, err_fp;
    logic [AN-1:0]   if_addr, if_addr_fp;

    typedef struct {
        int            port;
        logic [DN-1:0] d;
        int            due;
    } ret_t;

    ret_t rd_q[$];
    int   grant_q[$];
    int   total = 0;
    int   bad   = 0;

    sdram_port_mux #(.N(N), .AN(AN), .DN(DN), .RR(1), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .data(data),
        .rdy(rdy), .rd_valid(rd_valid), .rd_data(rd_data),
        .if_req(if_req), .if_we(if_we), .if_addr(if_addr), .if_data(if_data),
        .if_rdy(if_rdy), .if_rdy_out(if_rdy_out), .if_data_out(if_data_out), .err(err)
    );

    sdram_port_mux #(.N(N), .AN(AN), .DN(DN), .RR(0), .DEPTH(DEPTH)) dut_fp (
        .clk(clk), .reset(reset), .req(req_fp), .we(we), .addr(addr), .data(data),
        .rdy(rdy_fp), .rd_valid(rd_valid_fp), .rd_data(rd_data_fp),
        .if_req(if_req_fp), .if_we(if_we_fp), .if_addr(if_addr_fp), .if_data(if_data_fp),
        .if_rdy(if_rdy), .if_rdy_out(if_rdy_out), .if_data_out(if_data_out), .err(err_fp)
    );

    always #5 clk = ~clk;

    function automatic ret_t mk_ret(int p, logic [DN-1:0] d, int due);
        ret_t e;
        e.port = p;
        e.d    = d;
        e.due  = due;
        return e;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req         = '0;
        req_fp      = '0;
        we          = '0;
        addr        = '0;
        data        = '0;
        if_rdy      = 1'b1;
        if_rdy_out  = 1'b0;
        if_data_out = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        rd_q.delete();
        grant_q.delete();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        sample();
        total++; if (if_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_if_req got=%0h want=0", if_req); end
        total++; if (if_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_if_we got=%0h want=0", if_we); end
        total++; if (if_addr !== '0) begin bad++; $display("[TB] FAIL reset_if_addr got=%0h want=0", if_addr); end
        total++; if (if_data !== '0) begin bad++; $display("[TB] FAIL reset_if_data got=%0h want=0", if_data); end
        total++; if (rdy !== '0) begin bad++; $display("[TB] FAIL reset_rdy got=%0h want=0", rdy); end
        total++; if (rd_valid !== '0) begin bad++; $display("[TB] FAIL reset_rd_valid got=%0h want=0", rd_valid); end
        total++; if (rd_data !== '0) begin bad++; $display("[TB] FAIL reset_rd_data got=%0h want=0", rd_data); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%0h want=0", err); end
        total++; if (if_req_fp !== 1'b0) begin bad++; $display("[TB] FAIL reset_fp_if_req got=%0h want=0", if_req_fp); end
        total++; if (err_fp !== 1'b0) begin bad++; $display("[TB] FAIL reset_fp_err got=%0h want=0", err_fp); end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        logic [N-1:0] exp_rdy;
        logic         exp_ifreq;
        ret_t         e;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            req        = '0;
            we         = '0;
            if_rdy_out = 1'b0;
            addr[2*AN +: AN] = 24'h001234;
            exp_rdy   = '0;
            exp_ifreq = 1'b0;
            case (c)
                0: req = 4'b0100;
                1: begin req = 4'b0100; exp_rdy = 4'b0100; exp_ifreq = 1'b1; end
                3: begin if_rdy_out = 1'b1; if_data_out = 16'hBEEF; rd_q.push_back(mk_ret(2, 16'hBEEF, 4)); end
                default: ;
            endcase
            sample();
            total++; if (if_req !== exp_ifreq) begin bad++; $display("[TB] FAIL sr_if_req c=%0d got=%0h want=%0h", c, if_req, exp_ifreq); end
            total++; if (rdy !== exp_rdy) begin bad++; $display("[TB] FAIL sr_rdy c=%0d got=%0h want=%0h", c, rdy, exp_rdy); end
            if (c == 1) begin
                total++; if (if_addr !== 24'h001234) begin bad++; $display("[TB] FAIL sr_if_addr got=%0h want=001234", if_addr); end
                total++; if (if_we !== 1'b0) begin bad++; $display("[TB] FAIL sr_if_we got=%0h want=0", if_we); end
            end
            if (rd_q.size() > 0 && rd_q[0].due == c) begin
                e = rd_q.pop_front();
                total++; if (rd_valid !== N'(1 << e.port)) begin bad++; $display("[TB] FAIL sr_rd_valid got=%0h want=%0h", rd_valid, N'(1 << e.port)); end
                total++; if (rd_data !== e.d) begin bad++; $display("[TB] FAIL sr_rd_data got=%0h want=%0h", rd_data, e.d); end
            end else begin
                total++; if (rd_valid !== '0) begin bad++; $display("[TB] FAIL sr_rd_idle c=%0d got=%0h want=0", c, rd_valid); end
            end
        end
        total++; if (rd_q.size() != 0) begin bad++; $display("[TB] FAIL sr_missing got=%0d want=0", rd_q.size()); end
    endtask

    // Mode 0 drives the round-robin instance, mode 1 the fixed-priority one.
    task automatic test_write_arbitration();
        int            served[N];
        int            lim[N];
        int            exp_p;
        int            last_t;
        logic [N-1:0]  r;
        logic [AN-1:0] a;
        logic [DN-1:0] dd;
        for (int m = 0; m < 2; m++) begin
            do_reset();
            if (m == 0) begin
                lim = '{3, 3, 3, 3};
                for (int k = 0; k < 12; k++) grant_q.push_back(k % N);
            end else begin
                lim = '{3, 1, 1, 1};
                grant_q.push_back(0); grant_q.push_back(0); grant_q.push_back(0);
                grant_q.push_back(1); grant_q.push_back(2); grant_q.push_back(3);
            end
            served = '{0, 0, 0, 0};
            last_t = -1;
            for (int c = 0; c < 60 && grant_q.size() > 0; c++) begin
                next_cycle();
                for (int i = 0; i < N; i++) begin
                    if (m == 0) req[i] = (served[i] < lim[i]);
                    else        req_fp[i] = (served[i] < lim[i]);
                    we[i] = 1'b1;
                    addr[i*AN +: AN] = AN'(i * 'h10000 + served[i]);
                    data[i*DN +: DN] = DN'(i * 'h100 + served[i]);
                end
                sample();
                r  = (m == 0) ? rdy : rdy_fp;
                a  = (m == 0) ? if_addr : if_addr_fp;
                dd = (m == 0) ? if_data : if_data_fp;
                if (r !== '0) begin
                    exp_p = grant_q.pop_front();
                    total++; if (r !== N'(1 << exp_p)) begin bad++; $display("[TB] FAIL arb_grant m=%0d got=%0h want=%0h", m, r, N'(1 << exp_p)); end
                    total++; if (a !== AN'(exp_p * 'h10000 + served[exp_p])) begin bad++; $display("[TB] FAIL arb_addr m=%0d got=%0h want=%0h", m, a, AN'(exp_p * 'h10000 + served[exp_p])); end
                    total++; if (dd !== DN'(exp_p * 'h100 + served[exp_p])) begin bad++; $display("[TB] FAIL arb_data m=%0d got=%0h want=%0h", m, dd, DN'(exp_p * 'h100 + served[exp_p])); end
                    if (last_t >= 0) begin
                        total++; if (c - last_t != 2) begin bad++; $display("[TB] FAIL arb_gap m=%0d got=%0d want=2", m, c - last_t); end
                    end
                    last_t = c;
                    for (int i = 0; i < N; i++) if (r[i]) served[i]++;
                end
            end
            total++; if (grant_q.size() != 0) begin bad++; $display("[TB] FAIL arb_timeout m=%0d got=%0d want=0", m, grant_q.size()); end
        end
    endtask

    task automatic test_fifo_depth();
        int n1;
        int n3;
        do_reset();
        n1 = 0;
        n3 = 0;
        for (int c = 0; c < 40 && n1 < 8; c++) begin
            next_cycle();
            req = 4'b0010;
            we  = '0;
            addr[AN +: AN] = AN'(n1);
            sample();
            if (rdy !== '0) begin
                total++; if (rdy !== 4'b0010) begin bad++; $display("[TB] FAIL depth_fill got=%0h want=2", rdy); end
                n1++;
            end
        end
        total++; if (n1 != 8) begin bad++; $display("[TB] FAIL depth_fill_count got=%0d want=8", n1); end
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            req = {(n3 == 0), 1'b0, 1'b1, 1'b0};
            we  = 4'b1000;
            sample();
            total++; if (rdy[1] !== 1'b0) begin bad++; $display("[TB] FAIL depth_blocked c=%0d got=%0h want=0", c, rdy); end
            if (rdy[3] === 1'b1) n3++;
        end
        total++; if (n3 != 1) begin bad++; $display("[TB] FAIL depth_write got=%0d want=1", n3); end
        next_cycle();
        req = 4'b0010; we = '0; if_rdy_out = 1'b1; if_data_out = 16'h1111;
        sample();
        total++; if (rdy !== '0) begin bad++; $display("[TB] FAIL depth_pre got=%0h want=0", rdy); end
        next_cycle();
        if_rdy_out = 1'b0;
        sample();
        total++; if (rd_valid !== 4'b0010) begin bad++; $display("[TB] FAIL depth_rv got=%0h want=2", rd_valid); end
        total++; if (rd_data !== 16'h1111) begin bad++; $display("[TB] FAIL depth_rd_data got=%0h want=1111", rd_data); end
        total++; if (rdy !== '0) begin bad++; $display("[TB] FAIL depth_eval got=%0h want=0", rdy); end
        next_cycle();
        sample();
        total++; if (rdy !== 4'b0010) begin bad++; $display("[TB] FAIL depth_unblock got=%0h want=2", rdy); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL depth_err got=%0h want=0", err); end
    endtask

    task automatic test_interleave();
        logic [N-1:0] exp_rdy;
        logic         exp_err;
        ret_t         e;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            next_cycle();
            req = '0; we = '0; if_rdy_out = 1'b0; exp_rdy = '0;
            case (c)
                0: req = 4'b0001;
                1: begin req = 4'b0001; exp_rdy = 4'b0001; end
                2: req = 4'b0100;
                3: begin req = 4'b0100; exp_rdy = 4'b0100; end
                4: req = 4'b0010;
                5: begin req = 4'b0010; exp_rdy = 4'b0010; if_rdy_out = 1'b1; if_data_out = 16'h000A; rd_q.push_back(mk_ret(0, 16'h000A, c + 1)); end
                7: begin if_rdy_out = 1'b1; if_data_out = 16'h000B; rd_q.push_back(mk_ret(2, 16'h000B, c + 1)); end
                8: begin if_rdy_out = 1'b1; if_data_out = 16'h000C; rd_q.push_back(mk_ret(1, 16'h000C, c + 1)); end
                10: begin if_rdy_out = 1'b1; if_data_out = 16'h000D; end
                default: ;
            endcase
            sample();
            exp_err = (c >= 11);
            total++; if (rdy !== exp_rdy) begin bad++; $display("[TB] FAIL il_rdy c=%0d got=%0h want=%0h", c, rdy, exp_rdy); end
            total++; if (err !== exp_err) begin bad++; $display("[TB] FAIL il_err c=%0d got=%0h want=%0h", c, err, exp_err); end
            if (rd_q.size() > 0 && rd_q[0].due == c) begin
                e = rd_q.pop_front();
                total++; if (rd_valid !== N'(1 << e.port)) begin bad++; $display("[TB] FAIL il_rd_valid c=%0d got=%0h want=%0h", c, rd_valid, N'(1 << e.port)); end
                total++; if (rd_data !== e.d) begin bad++; $display("[TB] FAIL il_rd_data c=%0d got=%0h want=%0h", c, rd_data, e.d); end
            end else begin
                total++; if (rd_valid !== '0) begin bad++; $display("[TB] FAIL il_rd_idle c=%0d got=%0h want=0", c, rd_valid); end
            end
        end
        total++; if (rd_q.size() != 0) begin bad++; $display("[TB] FAIL il_missing got=%0d want=0", rd_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic         exp_ifreq;
        logic         exp_err;
        logic [N-1:0] exp_rdy;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            req = '0; we = '0; if_rdy = 1'b1; if_rdy_out = 1'b0; reset = 1'b0;
            addr[0 +: AN]  = 24'hABCDEF;
            addr[AN +: AN] = 24'h000111;
            exp_rdy = '0;
            case (c)
                0: begin req = 4'b0010; if_rdy_out = 1'b1; if_data_out = 16'h5555; end
                1: begin req = 4'b0010; exp_rdy = 4'b0010; end
                2, 3: begin req = 4'b0001; if_rdy = 1'b0; end
                4: begin req = 4'b0001; if_rdy = 1'b0; reset = 1'b1; end
                6: begin if_rdy_out = 1'b1; if_data_out = 16'h6666; end
                default: ;
            endcase
            exp_ifreq = (c == 1) || (c == 3) || (c == 4);
            exp_err   = ((c >= 1) && (c <= 4)) || (c >= 7);
            sample();
            total++; if (if_req !== exp_ifreq) begin bad++; $display("[TB] FAIL rm_if_req c=%0d got=%0h want=%0h", c, if_req, exp_ifreq); end
            total++; if (err !== exp_err) begin bad++; $display("[TB] FAIL rm_err c=%0d got=%0h want=%0h", c, err, exp_err); end
            total++; if (rdy !== exp_rdy) begin bad++; $display("[TB] FAIL rm_rdy c=%0d got=%0h want=%0h", c, rdy, exp_rdy); end
            total++; if (rd_valid !== '0) begin bad++; $display("[TB] FAIL rm_rd_valid c=%0d got=%0h want=0", c, rd_valid); end
            if (c == 3 || c == 4) begin
                total++; if (if_addr !== 24'hABCDEF) begin bad++; $display("[TB] FAIL rm_hold_addr c=%0d got=%0h want=abcdef", c, if_addr); end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_write_arbitration();
        test_fifo_depth();
        test_interleave();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
